pdn_domain_sequencer: RTL

Supply-side power sequencer for the chip power distribution network: the responder to the per-domain power requests raised by the consuming blocks. It drives one supply-switch enable per VDD domain, brings domains up or down strictly one at a time, waits for each domain's power-good, and acknowledges only after a fixed settle time. It sits between the top-level supply pins and the block instances, one bit per VDD net.

---
 rtl/pdn_pkg.sv | 16 +
 rtl/pdn_domain_sequencer_prio_pick.sv | 25 ++
 rtl/pdn_domain_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pdn_pkg.sv
// Shared types and default constants for the PDN domain sequencer.
package pdn_pkg;

    localparam int unsigned PDN_N_DOM       = 6;
    localparam int unsigned PDN_SETTLE_CYC  = 16;
    localparam int unsigned PDN_TIMEOUT_CYC = 255;
    localparam int unsigned PDN_CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_UP = 2'd1,
        WAIT_DN = 2'd2,
        SETTLE  = 2'd3
    } pdn_state_e;

endpackage

// File: rtl/pdn_domain_sequencer_prio_pick.sv
// Combinational lowest-index picker over the candidate domains.
module pdn_prio_pick
    import pdn_pkg::*;
#(
    parameter int unsigned N     = PDN_N_DOM,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     cand_i,
    output logic             valid_c_o,
    output logic [IDX_W-1:0] idx_c_o
);

    // Scan high to low so the lowest set index is written last and wins.
    always_comb begin
        valid_c_o = 1'b0;
        idx_c_o   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (cand_i[i]) begin
                valid_c_o = 1'b1;
                idx_c_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pdn_domain_sequencer.sv
// One-at-a-time VDD domain power sequencer with power-good settle timing.
// Optional power-good timeout/fault handling is enabled with PDN_TIMEOUT_EN.
module pdn_domain_sequencer
    import pdn_pkg::*;
#(
    parameter int unsigned N_DOM       = PDN_N_DOM,
    parameter int unsigned SETTLE_CYC  = PDN_SETTLE_CYC,
    parameter int unsigned TIMEOUT_CYC = PDN_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_DOM-1:0] req_i,
    input  logic [N_DOM-1:0] pgood_i,
    output logic [N_DOM-1:0] sw_en_o,
    output logic [N_DOM-1:0] ack_o,
    output logic             busy_o,
    output logic [N_DOM-1:0] fault_o
);

    localparam int unsigned          IDX_W       = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [PDN_CNT_W-1:0] SETTLE_LAST = PDN_CNT_W'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
        $error("SETTLE_CYC must be in 1..255");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..255");
    end

    pdn_state_e           state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic                 dir_q, dir_d;
    logic [PDN_CNT_W-1:0] cnt_q, cnt_d;
    logic [N_DOM-1:0]     sw_en_q, sw_en_d;
    logic [N_DOM-1:0]     ack_q, ack_d;
    logic [N_DOM-1:0]     fault_q, fault_d;
    logic                 busy_q, busy_d;

`ifdef PDN_TIMEOUT_EN
    localparam logic [PDN_CNT_W-1:0] TIMEOUT_LAST = PDN_CNT_W'(TIMEOUT_CYC - 1);
    logic [PDN_CNT_W-1:0] wcnt_q, wcnt_d;
`endif

    logic [N_DOM-1:0] cand_c;
    logic             pick_valid_c;
    logic [IDX_W-1:0] pick_idx_c;
    logic             pg_sel_c;

    assign cand_c   = (req_i ^ ack_q) & ~fault_q;
    assign pg_sel_c = pgood_i[sel_q];

    pdn_prio_pick #(
        .N     (N_DOM),
        .IDX_W (IDX_W)
    ) u_pick (
        .cand_i    (cand_c),
        .valid_c_o (pick_valid_c),
        .idx_c_o   (pick_idx_c)
    );

    // Next-state logic; dir_q holds the target power-good level of sel.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        sw_en_d = sw_en_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
`ifdef PDN_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        fault_d = fault_q & req_i;
`else
        fault_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    sel_d               = pick_idx_c;
                    dir_d               = req_i[pick_idx_c];
                    sw_en_d[pick_idx_c] = req_i[pick_idx_c];
                    busy_d              = 1'b1;
                    state_d             = req_i[pick_idx_c] ? WAIT_UP : WAIT_DN;
`ifdef PDN_TIMEOUT_EN
                    wcnt_d              = '0;
`endif
                end
            end
            WAIT_UP, WAIT_DN: begin
                if (pg_sel_c == dir_q) begin
                    cnt_d   = SETTLE_LAST;
                    state_d = SETTLE;
                end
`ifdef PDN_TIMEOUT_EN
                else if (wcnt_q == TIMEOUT_LAST) begin
                    sw_en_d[sel_q] = 1'b0;
                    ack_d[sel_q]   = 1'b0;
                    fault_d[sel_q] = 1'b1;
                    busy_d         = 1'b0;
                    state_d        = IDLE;
                end else begin
                    wcnt_d = wcnt_q + PDN_CNT_W'(1);
                end
`endif
            end
            SETTLE: begin
                if (pg_sel_c != dir_q) begin
                    state_d = dir_q ? WAIT_UP : WAIT_DN;
`ifdef PDN_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                end else if (cnt_q == '0) begin
                    ack_d[sel_q] = dir_q;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - PDN_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            sw_en_q <= '0;
            ack_q   <= '0;
            fault_q <= '0;
            busy_q  <= 1'b0;
`ifdef PDN_TIMEOUT_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            sw_en_q <= sw_en_d;
            ack_q   <= ack_d;
            fault_q <= fault_d;
            busy_q  <= busy_d;
`ifdef PDN_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    assign sw_en_o = sw_en_q;
    assign ack_o   = ack_q;
    assign busy_o  = busy_q;
    assign fault_o = fault_q;

endmodule
